// File: rtl/ddc_decim_ctrl_pkg.sv
// Shared DDC definitions: default stage count and widths, sequencer state
// encoding, and a helper for index widths that stays legal for one stage.
package ddc_decim_ctrl_pkg;

  localparam int unsigned DDC_NUM_STAGES = 3;
  localparam int unsigned DDC_RATIO_W    = 8;   // ratio and per-stage counter width
  localparam int unsigned DDC_OUT_CNT_W  = 16;  // out_count width

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } ddc_state_e;

  // Width of a stage index; never narrower than one bit.
  function automatic int unsigned ddc_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ddc_decim_stage_cnt.sv
// One decimation stage: counts input strobes, wraps at ratio-1 and emits a
// same-cycle output strobe on the wrapping input.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   clear        hold the counter at zero
//   in_stb       input strobe for this stage
//   ratio        active decimation ratio (never 0)
//   stb_c        combinational output strobe
module ddc_decim_stage_cnt
  import ddc_decim_ctrl_pkg::*;
#(
  parameter int unsigned RATIO_W = DDC_RATIO_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               in_stb,
  input  logic [RATIO_W-1:0] ratio,
  output logic               stb_c
);

  logic [RATIO_W-1:0] cnt_q;
  logic [RATIO_W-1:0] ratio_m1_c;
  logic               wrap_c;

  // A ratio of 1 makes ratio-1 zero, so every strobe passes and cnt stays 0.
  assign ratio_m1_c = RATIO_W'(ratio - RATIO_W'(1));
  assign wrap_c     = (cnt_q == ratio_m1_c);
  assign stb_c      = in_stb && wrap_c;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cnt_q <= '0;
    end else if (in_stb) begin
      cnt_q <= wrap_c ? '0 : RATIO_W'(cnt_q + RATIO_W'(1));
    end
  end

endmodule

// File: rtl/ddc_decim_ctrl.sv
// Decimation sequencer for a cascade of NUM_STAGES decimators. Generates
// per-stage capture strobes, and stages ratio updates through shadow
// registers so new ratios only take effect on a frame boundary.
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   enable                 run request (0 returns to IDLE)
//   in_valid               front-end sample strobe
//   cfg_valid/cfg_ready    ratio write handshake
//   cfg_stage, cfg_ratio   write target stage and ratio
//   stage_en               registered per-stage capture strobes
//   out_valid              final-stage strobe
//   out_count              final-stage strobes since leaving IDLE
//   cfg_err                sticky bad-write flag
module ddc_decim_ctrl
  import ddc_decim_ctrl_pkg::*;
#(
  parameter  int unsigned NUM_STAGES = DDC_NUM_STAGES,
  parameter  int unsigned RATIO_W    = DDC_RATIO_W,
  localparam int unsigned STAGE_W    = ddc_idx_w(NUM_STAGES)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     in_valid,
  input  logic                     cfg_valid,
  input  logic [STAGE_W-1:0]       cfg_stage,
  input  logic [RATIO_W-1:0]       cfg_ratio,
  output logic                     cfg_ready,
  output logic [NUM_STAGES-1:0]    stage_en,
  output logic                     out_valid,
  output logic [DDC_OUT_CNT_W-1:0] out_count,
  output logic                     cfg_err
);

  ddc_state_e state_q, state_d;

  logic [NUM_STAGES-1:0][RATIO_W-1:0] r_q, r_d;   // active ratios
  logic [NUM_STAGES-1:0][RATIO_W-1:0] s_q, s_d;   // shadow ratios

  logic [NUM_STAGES-1:0] stb_in_c;
  logic [NUM_STAGES-1:0] stb_c;
  logic                  run_c;
  logic                  final_c;
  logic                  cfg_acc_c;
  logic                  range_ok_c;
  logic                  wr_ok_c;
  logic                  wr_err_c;
  logic [RATIO_W-1:0]    wr_ratio_c;
  logic                  r_load_s_c;

  // Counting only while running with enable still high, so an enable drop
  // never produces a strobe on the way to IDLE.
  assign run_c   = (state_q != ST_IDLE) && enable;
  assign final_c = stb_c[NUM_STAGES-1];

  // Strobe cascade: stage 0 sees in_valid, stage k sees stage k-1's strobe.
  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign stb_in_c[k] = in_valid && run_c;
    end else begin : g_next
      assign stb_in_c[k] = stb_c[k-1];
    end

    ddc_decim_stage_cnt #(
      .RATIO_W (RATIO_W)
    ) u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (!run_c),
      .in_stb (stb_in_c[k]),
      .ratio  (r_q[k]),
      .stb_c  (stb_c[k])
    );
  end

  // Config write decode; a zero ratio is stored as 1.
  assign cfg_acc_c  = cfg_valid && cfg_ready;
  assign range_ok_c = (32'(cfg_stage) < NUM_STAGES);
  assign wr_ok_c    = cfg_acc_c && range_ok_c;
  assign wr_err_c   = cfg_acc_c && (!range_ok_c || (cfg_ratio == '0));
  assign wr_ratio_c = (cfg_ratio == '0) ? RATIO_W'(1) : cfg_ratio;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and ratio-register control.
  always_comb begin
    state_d    = state_q;
    r_load_s_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!enable) begin
          state_d    = ST_IDLE;
          r_load_s_c = 1'b1;
        end else if (wr_ok_c) begin
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        if (!enable) begin
          state_d    = ST_IDLE;
          r_load_s_c = 1'b1;
        end else if (final_c) begin
          // Frame boundary: every counter is wrapping this cycle.
          state_d    = ST_RUN;
          r_load_s_c = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Shadow writes land in every state that accepts them; active ratios take
  // the write directly only in IDLE, otherwise they copy the shadows.
  always_comb begin
    s_d = s_q;
    r_d = r_q;
    for (int k = 0; k < int'(NUM_STAGES); k++) begin
      if (wr_ok_c && (cfg_stage == STAGE_W'(k))) begin
        s_d[k] = wr_ratio_c;
        if (state_q == ST_IDLE) r_d[k] = wr_ratio_c;
      end
    end
    if (r_load_s_c) r_d = s_d;
  end

  // Registered ratios and outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q       <= {NUM_STAGES{RATIO_W'(1)}};
      r_q       <= {NUM_STAGES{RATIO_W'(1)}};
      stage_en  <= '0;
      out_count <= '0;
      cfg_err   <= 1'b0;
      cfg_ready <= 1'b1;
    end else begin
      s_q       <= s_d;
      r_q       <= r_d;
      stage_en  <= stb_c;
      cfg_ready <= (state_d != ST_PEND);
      if (wr_err_c) cfg_err <= 1'b1;
      if (state_d == ST_IDLE) begin
        out_count <= '0;
      end else if (final_c) begin
        out_count <= DDC_OUT_CNT_W'(out_count + DDC_OUT_CNT_W'(1));
      end
    end
  end

  assign out_valid = stage_en[NUM_STAGES-1];

endmodule
